// File: rtl/hcsr04_scheduler_if.sv
// Sensor-side and result-side signals of the HC-SR04 scheduler.
// The master modport belongs to whatever drives the sensor pins; the slave modport belongs to the scheduler.
interface hcsr04_scheduler_if #(
    parameter int unsigned N_SENS = 4
);
    logic              enable;
    logic [N_SENS-1:0] echo;
    logic [N_SENS-1:0] trigger;
    logic              meas_valid;
    logic [2:0]        meas_id;
    logic [15:0]       meas_us;
    logic              meas_timeout;
    logic              busy;

    modport master (
        output enable, echo,
        input  trigger, meas_valid, meas_id, meas_us, meas_timeout, busy
    );

    modport slave (
        input  enable, echo,
        output trigger, meas_valid, meas_id, meas_us, meas_timeout, busy
    );
endinterface

// File: rtl/hcsr04_scheduler.sv
// Round-robin HC-SR04 scheduler: fires one sensor at a time, times its echo in us,
// and then waits a guard interval before the next sensor so that echoes do not cross-talk.
module hcsr04_scheduler #(
    parameter int unsigned N_SENS      = 4,
    parameter int unsigned US_CYC      = 25,
    parameter int unsigned TRIG_US     = 10,
    parameter int unsigned RISE_TO_US  = 1000,
    parameter int unsigned ECHO_MAX_US = 25000,
    parameter int unsigned GUARD_US    = 10000
) (
    input  logic                 clk,
    input  logic                 rst,
    hcsr04_scheduler_if.slave    bus
);
    localparam int unsigned PW = (US_CYC > 1) ? $clog2(US_CYC) : 1;
    localparam int unsigned UW = 16;
    localparam int unsigned IW = 3;

    typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, GUARD} state_t;

    state_t            state_q;
    logic [N_SENS-1:0] echo_m_q, echo_s_q, trigger_q;
    logic [PW-1:0]     pre_q;
    logic [UW-1:0]     us_q, meas_us_q;
    logic [IW-1:0]     idx_q, meas_id_q;
    logic              meas_valid_q, meas_timeout_q, busy_q;

    logic              tick;
    logic              echo_sel;
    logic [UW-1:0]     us_inc;
    logic [IW-1:0]     idx_nxt;
    logic [N_SENS-1:0] sel_mask;

    // Mask selection instead of echo_s_q[idx_q] so that the index width never has to match N_SENS
    assign tick     = (pre_q == PW'(US_CYC - 1));
    assign sel_mask = N_SENS'(1) << idx_q;
    assign echo_sel = |(echo_s_q & sel_mask);
    assign us_inc   = (tick && (us_q != '1)) ? us_q + UW'(1) : us_q;
    assign idx_nxt  = (idx_q == IW'(N_SENS - 1)) ? '0 : idx_q + IW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            echo_m_q       <= '0;
            echo_s_q       <= '0;
            trigger_q      <= '0;
            pre_q          <= '0;
            us_q           <= '0;
            idx_q          <= '0;
            meas_id_q      <= '0;
            meas_us_q      <= '0;
            meas_valid_q   <= 1'b0;
            meas_timeout_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            echo_m_q     <= bus.echo;
            echo_s_q     <= echo_m_q;
            meas_valid_q <= 1'b0;
            pre_q        <= tick ? '0 : pre_q + PW'(1);
            us_q         <= us_inc;

            // Every state transition below also restarts the prescaler and the us counter
            unique case (state_q)
                IDLE: begin
                    if (bus.enable) begin
                        state_q   <= TRIG;
                        trigger_q <= sel_mask;
                        busy_q    <= 1'b1;
                        pre_q     <= '0;
                        us_q      <= '0;
                    end
                end
                TRIG: begin
                    if (tick && (us_q == UW'(TRIG_US - 1))) begin
                        state_q   <= WAIT_RISE;
                        trigger_q <= '0;
                        pre_q     <= '0;
                        us_q      <= '0;
                    end
                end
                WAIT_RISE: begin
                    if (echo_sel) begin
                        state_q <= MEASURE;
                        pre_q   <= '0;
                        us_q    <= '0;
                    end else if (tick && (us_q == UW'(RISE_TO_US - 1))) begin
                        state_q        <= GUARD;
                        meas_valid_q   <= 1'b1;
                        meas_id_q      <= idx_q;
                        meas_us_q      <= '0;
                        meas_timeout_q <= 1'b1;
                        pre_q          <= '0;
                        us_q           <= '0;
                    end
                end
                MEASURE: begin
                    // The cycle in which the fall is seen still contributes its tick
                    if (!echo_sel) begin
                        state_q        <= GUARD;
                        meas_valid_q   <= 1'b1;
                        meas_id_q      <= idx_q;
                        meas_us_q      <= us_inc;
                        meas_timeout_q <= 1'b0;
                        pre_q          <= '0;
                        us_q           <= '0;
                    end else if (us_inc == UW'(ECHO_MAX_US)) begin
                        state_q        <= GUARD;
                        meas_valid_q   <= 1'b1;
                        meas_id_q      <= idx_q;
                        meas_us_q      <= '0;
                        meas_timeout_q <= 1'b1;
                        pre_q          <= '0;
                        us_q           <= '0;
                    end
                end
                GUARD: begin
                    if (tick && (us_q == UW'(GUARD_US - 1))) begin
                        idx_q <= idx_nxt;
                        pre_q <= '0;
                        us_q  <= '0;
                        if (bus.enable) begin
                            state_q   <= TRIG;
                            trigger_q <= N_SENS'(1) << idx_nxt;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    trigger_q <= '0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.trigger      = trigger_q;
    assign bus.meas_valid   = meas_valid_q;
    assign bus.meas_id      = meas_id_q;
    assign bus.meas_us      = meas_us_q;
    assign bus.meas_timeout = meas_timeout_q;
    assign bus.busy         = busy_q;
endmodule
